sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Single-clock arbiter sharing the one SRAM controller port among up to N_PORTS requesters (port 0 = display scanout, 1 = rasterizer writes, 2 = texture reads, 3 = SPI/host register access).
- Each requester sees the same req/we/addr/wdata/rdata/ack/ready handshake it would see on a dedicated SRAM controller.
- Port 0 has priority with bounded starvation of the others; ports 1..N_PORTS-1 are served round-robin.

Parameters:
- N_PORTS, 4, number of requesters (2..8).
- ADDR_W, 24, word address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 16, consecutive port-0 grants allowed while any other port is pending (1..255).

Ports:
- clk_sram  in  1  SRAM-domain clock (100 MHz).
- rst_n_sram  in  1  asynchronous active-low reset.
- req  in  N_PORTS  per-port request level; held until that port's ack.
- we  in  N_PORTS  per-port write enable.
- addr  in  N_PORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_PORTS*DATA_W  per-port write data.
- ack  out  N_PORTS  one-cycle completion pulse per port.
- ready  out  N_PORTS  port may assert req this cycle.
- rdata  out  DATA_W  shared registered read data.
- grant_id  out  3  index of the port owning the current or last transaction.
- mem_req  out  1  request to SRAM controller.
- mem_we  out  1  write enable to SRAM controller.
- mem_addr  out  ADDR_W  address to SRAM controller.
- mem_wdata  out  DATA_W  write data to SRAM controller.
- mem_rdata  in  DATA_W  SRAM controller read data, valid with mem_ack.
- mem_ack  in  1  SRAM controller completion.
- mem_ready  in  1  SRAM controller can accept a request.

Behaviour:
- Reset values: mem_req, mem_we, ack, grant_id, rdata, mem_addr, mem_wdata, starve counter and RR pointer = 0; state IDLE.
- ready[i] = (state==IDLE) && mem_ready, combinational and identical for all ports.
- FSM states: IDLE, WAIT_ACK, RESP.
- IDLE, when mem_ready and at least one eligible req:
  - Pick a winner.
  - Register mem_req=1 and mem_we/mem_addr/mem_wdata from the winner.
  - Set grant_id to the winner and go to WAIT_ACK.
  - The first mem_req cycle is one cycle after req is sampled.
- IDLE with no eligible req, or mem_ready=0: stay in IDLE; mem_req stays 0.
- WAIT_ACK: mem_req and request fields are held stable. On mem_ack:
  - mem_req<=0.
  - If the transaction was a read, rdata<=mem_rdata; writes leave rdata unchanged.
  - ack[grant_id]<=1; go to RESP.
- RESP: ack high for exactly this cycle. Next state is IDLE.
- Response timing: the requester sees ack one cycle after mem_ack. rdata stays stable until the next read's mem_ack, so it is valid for at least 2 cycles after ack rises.
- Eligibility:
  - The port acked in the preceding RESP is masked for the first IDLE cycle after RESP. This lets a requester that clears req on seeing ack avoid a double grant.
  - All other pending ports are eligible immediately.
- Winner selection:
  - Port 0 wins if eligible and starve_cnt < STARVE_LIMIT.
  - Otherwise the first eligible port in 1..N_PORTS-1 at or after rr_ptr, wrapping, wins.
  - If only port 0 is eligible, it wins regardless of starve_cnt.
- starve_cnt (8-bit):
  - Increments on each port-0 grant made while any port 1..N-1 req is high; saturates at 255.
  - Clears on any non-port-0 grant, or on a port-0 grant with no other req high.
- rr_ptr: after granting port k>0, rr_ptr <= k+1, wrapping from N_PORTS-1 to 1.
- Deassertion: req dropped before grant means the request is not serviced. req dropped during WAIT_ACK is ignored; the transaction completes and ack still pulses.
- mem_ready low in IDLE: no grant. mem_ready is not checked in WAIT_ACK.
- Reset mid-transaction: all state returns to reset values immediately. The SRAM controller is reset in the same domain.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and output stats_grants (N_PORTS*16).
  - Per-port 16-bit counters increment on each ack[i] and saturate at 0xFFFF.
  - stats_clr=1 zeroes all counters, taking priority over a same-cycle increment.
  - Counters reset to 0.
- Undefined: ports and counters are absent; arbitration is identical.

Test Plan:
- Port 2 read, addr 0x000100, mem_rdata 0xDEADBEEF, mem_ack 3 cycles after mem_req -> mem_addr=0x000100, mem_we=0; ack[2] pulses 1 cycle after mem_ack; rdata=0xDEADBEEF held 2+ cycles; grant_id=2.
- Ports 0 and 1 request simultaneously, port 0 reissuing after each ack -> port 0 is granted first. With STARVE_LIMIT=16, port 1 is granted after exactly 16 port-0 grants, then starve_cnt=0.
- Ports 1, 2, 3 held continuously, port 0 idle -> grant order 1,2,3,1,2,3.
- Requester clears req on the cycle ack is seen -> no second mem_req for that port; total mem_req pulses equal 1.
- Port 1 write 0x12345678 to 0x0FFFFF with mem_ready=0 for 5 cycles -> ready=0 throughout, no mem_req. Grant occurs the cycle after mem_ready rises; mem_we=1, mem_wdata=0x12345678.
- SRAM_ARB_STATS_EN: 3 port-3 transactions -> stats_grants[3]=3. stats_clr coincident with a 4th ack -> counter reads 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port among N_PORTS requesters.
// Port 0 (display) has priority with bounded starvation of the others;
// ports 1..N_PORTS-1 are served round-robin.
// Optional build macro SRAM_ARB_STATS_EN adds per-port saturating ack counters.
module sram_arbiter #(
   parameter int N_PORTS      = 4,
   parameter int ADDR_W       = 24,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                      clk_sram,
   input  logic                      rst_n_sram,
   input  logic [N_PORTS-1:0]        req,
   input  logic [N_PORTS-1:0]        we,
   input  logic [N_PORTS*ADDR_W-1:0] addr,
   input  logic [N_PORTS*DATA_W-1:0] wdata,
   output logic [N_PORTS-1:0]        ack,
   output logic [N_PORTS-1:0]        ready,
   output logic [DATA_W-1:0]         rdata,
   output logic [2:0]                grant_id,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ack,
   input  logic                      mem_ready
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic                      stats_clr,
   output logic [N_PORTS*16-1:0]     stats_grants
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

   localparam logic [7:0] LIMIT8    = 8'(STARVE_LIMIT);
   localparam logic [2:0] LAST_PORT = 3'(N_PORTS - 1);

   state_t               state, state_nxt;
   logic [7:0]           starve_cnt;
   logic [2:0]           rr_ptr;
   logic                 mask_en;
   logic [N_PORTS-1:0]   elig;
   logic [2:0]           rr_base;
   logic                 hi_vld, lo_vld;
   logic [2:0]           hi_win, lo_win;
   logic [2:0]           win;
   logic                 win_vld;
   logic                 grant_go;
   logic                 others_req;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic [N_PORTS-1:0]   ack_set;

   assign ready      = {N_PORTS{(state == IDLE) && mem_ready}};
   assign others_req = |req[N_PORTS-1:1];
   assign grant_go   = (state == IDLE) && mem_ready && win_vld;

   // Eligibility mask and winner selection (port-0 priority, round-robin for the rest)
   always_comb begin
      elig = req;
      // the port acked in the preceding RESP sits out the first IDLE cycle
      if (mask_en) begin
         for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_id == 3'(i)) elig[i] = 1'b0;
         end
      end
      rr_base = (rr_ptr == '0) ? 3'd1 : rr_ptr;
      hi_vld  = 1'b0;
      lo_vld  = 1'b0;
      hi_win  = '0;
      lo_win  = '0;
      // lowest eligible port at/after rr_base, and lowest overall for the wrap case
      for (int unsigned i = 1; i < N_PORTS; i++) begin
         if (elig[i] && !lo_vld) begin
            lo_vld = 1'b1;
            lo_win = 3'(i);
         end
         if (elig[i] && !hi_vld && (3'(i) >= rr_base)) begin
            hi_vld = 1'b1;
            hi_win = 3'(i);
         end
      end
      win     = '0;
      win_vld = 1'b0;
      if (elig[0] && ((starve_cnt < LIMIT8) || !lo_vld)) begin
         win_vld = 1'b1;
      end else if (hi_vld) begin
         win     = hi_win;
         win_vld = 1'b1;
      end else if (lo_vld) begin
         win     = lo_win;
         win_vld = 1'b1;
      end
   end

   // Mux the winner's request fields and decode the ack one-hot
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      ack_set   = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         if (win == 3'(i)) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
         if (grant_id == 3'(i)) ack_set[i] = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk_sram or negedge rst_n_sram) begin
      if (!rst_n_sram) state <= IDLE;
      else             state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (grant_go) state_nxt = WAIT_ACK;
         WAIT_ACK: if (mem_ack)  state_nxt = RESP;
         RESP:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Request/response datapath, starvation counter and round-robin pointer
   always_ff @(posedge clk_sram or negedge rst_n_sram) begin
      if (!rst_n_sram) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata      <= '0;
         ack        <= '0;
         grant_id   <= '0;
         starve_cnt <= '0;
         rr_ptr     <= '0;
         mask_en    <= 1'b0;
      end else begin
         ack     <= '0;
         mask_en <= (state == RESP);
         if (grant_go) begin
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            grant_id  <= win;
            if (win == '0) begin
               if (!others_req)             starve_cnt <= '0;
               else if (starve_cnt != '1)   starve_cnt <= starve_cnt + 8'd1;
            end else begin
               starve_cnt <= '0;
               rr_ptr     <= (win == LAST_PORT) ? 3'd1 : win + 3'd1;
            end
         end
         if ((state == WAIT_ACK) && mem_ack) begin
            mem_req <= 1'b0;
            ack     <= ack_set;
            if (!mem_we) rdata <= mem_rdata;
         end
      end
   end

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] grant_cnt [N_PORTS];

   // Per-port saturating ack counters; clear wins over a same-cycle increment
   always_ff @(posedge clk_sram or negedge rst_n_sram) begin
      if (!rst_n_sram) begin
         for (int unsigned i = 0; i < N_PORTS; i++) grant_cnt[i] <= '0;
      end else if (stats_clr) begin
         for (int unsigned i = 0; i < N_PORTS; i++) grant_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (ack[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 16'd1;
         end
      end
   end

   // Flatten counters onto the stats bus
   always_comb begin
      stats_grants = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) stats_grants[i*16 +: 16] = grant_cnt[i];
   end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter.
// Build with SRAM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_sram_arbiter;

   localparam int N  = 4;
   localparam int AW = 24;
   localparam int DW = 32;

   logic            clk_sram = 1'b0;
   logic            rst_n_sram;
   logic [N-1:0]    req, we, ack, ready;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
   logic [2:0]      grant_id;
   logic            mem_req, mem_we, mem_ack, mem_ready;
   logic [AW-1:0]   mem_addr;
`ifdef SRAM_ARB_STATS_EN
   logic            stats_clr;
   logic [N*16-1:0] stats_grants;
`endif

   sram_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(16)) dut (
      .clk_sram(clk_sram), .rst_n_sram(rst_n_sram),
      .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .ready(ready), .rdata(rdata), .grant_id(grant_id),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_ready(mem_ready)
`ifdef SRAM_ARB_STATS_EN
      , .stats_clr(stats_clr), .stats_grants(stats_grants)
`endif
   );

   always #5 clk_sram = ~clk_sram;

   typedef struct {
      int unsigned   port;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   // SRAM model state
   int            lat = 2;
   logic [DW-1:0] sram_val;
   bit            recov = 0;
   int            rp = 0;
   bit            busy = 0;
   int            cnt = 0;
   int            n_memreq = 0;
   int            ack_edge = 0;
   logic [AW-1:0] cap_a;
   logic          cap_w;
   logic [DW-1:0] cap_d;

   // requester model state
   int unsigned   remaining [N];
   bit            late [N];
   bit            clr_next [N];
   bit            hold_chk = 0;
   logic [DW-1:0] hold_val;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   always @(posedge clk_sram) cyc <= cyc + 1;

   // SRAM controller model: acks lat cycles after the first mem_req cycle
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk_sram);
         #1;
         if (rp > 0) begin
            rp--;
            if (rp == 0) mem_ready = 1'b1;
         end
         if (!rst_n_sram) begin
            busy    = 0;
            mem_ack = 1'b0;
         end else if (busy) begin
            cnt++;
            if (cnt < lat) begin
               check("mem_req_held", 64'(mem_req), 64'(1));
               check("mem_addr_held", 64'(mem_addr), 64'(cap_a));
            end
            if (cnt == lat - 1) begin
               mem_ack   = 1'b1;
               mem_rdata = sram_val;
               ack_edge  = cyc + 1;
            end else if (cnt == lat) begin
               mem_ack = 1'b0;
               busy    = 0;
               check("mem_req_drop", 64'(mem_req), 64'(0));
               if (recov) begin
                  mem_ready = 1'b0;
                  rp        = 2;
               end
            end
         end else if (mem_req) begin
            busy  = 1;
            cnt   = 0;
            n_memreq++;
            cap_a = mem_addr;
            cap_w = mem_we;
            cap_d = mem_wdata;
         end
      end
   end

   // Requesters: keep req while more transactions remain, else drop on ack (or one cycle late)
   initial begin
      forever begin
         @(negedge clk_sram);
         for (int p = 0; p < N; p++) begin
            if (clr_next[p]) begin
               req[p]      = 1'b0;
               clr_next[p] = 0;
            end
            if (rst_n_sram && ack[p]) begin
               if (remaining[p] > 0)  remaining[p]--;
               else if (late[p])      clr_next[p] = 1;
               else                   req[p] = 1'b0;
            end
         end
      end
   end

   // Monitor: pop the scoreboard on every ack pulse
   initial begin
      exp_t         e;
      logic [63:0]  oh;
      forever begin
         @(negedge clk_sram);
         if (rst_n_sram) begin
            if (hold_chk) begin
               check("rdata_hold", 64'(rdata), 64'(hold_val));
               hold_chk = 0;
            end
            if (ack != '0) begin
               if (sb.size() == 0) begin
                  check("unexpected_ack", 64'(ack), 64'(0));
               end else begin
                  e  = sb.pop_front();
                  oh = 64'(1) << e.port;
                  check("ack_port", 64'(ack), oh);
                  check("grant_id", 64'(grant_id), 64'(e.port));
                  check("mem_we", 64'(cap_w), 64'(e.w));
                  check("mem_addr", 64'(cap_a), 64'(e.a));
                  check("ack_latency", 64'(cyc), 64'(ack_edge));
                  if (e.w) begin
                     check("mem_wdata", 64'(cap_d), 64'(e.d));
                  end else begin
                     check("rdata", 64'(rdata), 64'(e.rd));
                     hold_chk = 1;
                     hold_val = e.rd;
                  end
               end
            end
         end
      end
   end

   task automatic expect_txn(input int unsigned p, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] rd);
      exp_t e;
      e.port = p; e.w = w; e.a = a; e.d = d; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int unsigned times);
      we[p]             = w;
      addr[p*AW +: AW]  = a;
      wdata[p*DW +: DW] = d;
      remaining[p]      = times - 1;
      req[p]            = 1'b1;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk_sram);
         k++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 64'(sb.size()), 64'(0));
         sb.delete();
      end
      repeat (4) @(negedge clk_sram);
   endtask

   task automatic do_reset();
      @(negedge clk_sram);
      req        = '0;
      rst_n_sram = 1'b0;
      mem_ready  = 1'b1;
      recov      = 0;
      rp         = 0;
      hold_chk   = 0;
      sb.delete();
      for (int p = 0; p < N; p++) begin
         remaining[p] = 0;
         late[p]      = 0;
         clr_next[p]  = 0;
      end
      repeat (2) @(negedge clk_sram);
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_ack", 64'(ack), 64'(0));
      check("rst_grant_id", 64'(grant_id), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_ready", 64'(ready), 64'(4'hF));
      rst_n_sram = 1'b1;
      @(negedge clk_sram);
      n_memreq = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      req = '0; we = '0; addr = '0; wdata = '0;
      mem_ready = 1'b1; sram_val = '0; rst_n_sram = 1'b0;
`ifdef SRAM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      do_reset();

      // single read on port 2, three-cycle SRAM latency
      lat = 3; sram_val = 32'hDEADBEEF;
      expect_txn(2, 1'b0, 24'h000100, 32'h0, 32'hDEADBEEF);
      issue(2, 1'b0, 24'h000100, 32'h0, 1);
      drain(60);

      // port 0 priority with starvation bound of 16, then port 1, then port 0 again
      do_reset();
      lat = 2; recov = 1; sram_val = 32'h0;
      for (int i = 0; i < 16; i++) expect_txn(0, 1'b1, 24'h000010, 32'h000000AA, 32'h0);
      expect_txn(1, 1'b1, 24'h000020, 32'h000000BB, 32'h0);
      expect_txn(0, 1'b1, 24'h000010, 32'h000000AA, 32'h0);
      issue(0, 1'b1, 24'h000010, 32'h000000AA, 17);
      issue(1, 1'b1, 24'h000020, 32'h000000BB, 1);
      drain(600);

      // ports 1..3 held continuously: round-robin 1,2,3,1,2,3
      do_reset();
      lat = 2; sram_val = 32'hA5A55A5A;
      for (int r = 0; r < 2; r++)
         for (int p = 1; p < N; p++) expect_txn(p, 1'b0, 24'(32'h100 + p), 32'h0, 32'hA5A55A5A);
      for (int p = 1; p < N; p++) issue(p, 1'b0, 24'(32'h100 + p), 32'h0, 2);
      drain(200);

      // requester drops req on ack, and one cycle late: exactly one mem_req each
      do_reset();
      lat = 2; sram_val = 32'h11112222;
      expect_txn(3, 1'b0, 24'h000003, 32'h0, 32'h11112222);
      issue(3, 1'b0, 24'h000003, 32'h0, 1);
      drain(60);
      repeat (6) @(negedge clk_sram);
      check("memreq_pulses", 64'(n_memreq), 64'(1));
      late[3] = 1; n_memreq = 0;
      expect_txn(3, 1'b0, 24'h000003, 32'h0, 32'h11112222);
      issue(3, 1'b0, 24'h000003, 32'h0, 1);
      drain(60);
      repeat (6) @(negedge clk_sram);
      check("memreq_pulses_late", 64'(n_memreq), 64'(1));

      // mem_ready low for 5 cycles; port 2 withdraws before any grant
      do_reset();
      mem_ready = 1'b0;
      expect_txn(1, 1'b1, 24'h0FFFFF, 32'h12345678, 32'h0);
      issue(1, 1'b1, 24'h0FFFFF, 32'h12345678, 1);
      issue(2, 1'b0, 24'h000222, 32'h0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sram);
         if (i == 2) req[2] = 1'b0;
         check("ready_low", 64'(ready), 64'(0));
         check("no_mem_req", 64'(mem_req), 64'(0));
      end
      mem_ready = 1'b1;
      #1;
      check("ready_high", 64'(ready), 64'(4'hF));
      @(posedge clk_sram);
      #1;
      check("grant_after_ready", 64'(mem_req), 64'(1));
      drain(60);
      check("withdrawn_not_served", 64'(n_memreq), 64'(1));

      // reset in the middle of a transaction
      do_reset();
      lat = 8;
      issue(1, 1'b0, 24'h000055, 32'h0, 1);
      k = 0;
      while (!mem_req && k < 20) begin
         @(negedge clk_sram);
         k++;
      end
      check("mid_rst_started", 64'(mem_req), 64'(1));
      repeat (2) @(negedge clk_sram);
      rst_n_sram = 1'b0;
      #1;
      check("mid_rst_mem_req", 64'(mem_req), 64'(0));
      check("mid_rst_grant_id", 64'(grant_id), 64'(0));
      check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
      do_reset();

`ifdef SRAM_ARB_STATS_EN
      // grant counters: three port-3 acks, then clear coincident with a fourth
      lat = 2;
      for (int i = 0; i < 3; i++) expect_txn(3, 1'b1, 24'h000333, 32'h33, 32'h0);
      issue(3, 1'b1, 24'h000333, 32'h33, 3);
      drain(100);
      check("stats_port3", 64'(stats_grants[3*16 +: 16]), 64'(3));
      check("stats_port0", 64'(stats_grants[0 +: 16]), 64'(0));
      expect_txn(3, 1'b1, 24'h000333, 32'h33, 32'h0);
      issue(3, 1'b1, 24'h000333, 32'h33, 1);
      k = 0;
      while (!ack[3] && k < 30) begin
         @(negedge clk_sram);
         k++;
      end
      check("stats_ack_seen", 64'(ack[3]), 64'(1));
      stats_clr = 1'b1;
      @(negedge clk_sram);
      stats_clr = 1'b0;
      check("stats_clr_wins", 64'(stats_grants[3*16 +: 16]), 64'(0));
      drain(60);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
